sd_axil_regfile: RTL and testbench
==================================

SD_AXIL_REGFILE -- requirements
Module: sd_axil_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, giving the bus/register width; legal values are 32 and 64.
REQ-002 SHALL have parameter NUM_REGS, default 4, giving the register count; legal range 2..64.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, giving the address width; must cover NUM_REGS*(DW/8) bytes.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 ACLK  in  1  clock; all logic is on its rising edge.
REQ-006 ARESETN  in  1  synchronous active-low reset.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID  in  AW/3/1  write address; AWPROT is ignored.
REQ-008 S_AXI_AWREADY  out  1  write address ready.
REQ-009 S_AXI_WDATA/WSTRB/WVALID  in  DW/DW/8/1  write data, byte strobes, valid.
REQ-010 S_AXI_WREADY  out  1  write data ready.
REQ-011 S_AXI_BRESP/BVALID  out  2/1 and S_AXI_BREADY  in  1  write response channel.
REQ-012 S_AXI_ARADDR/ARPROT/ARVALID  in  AW/3/1 and S_AXI_ARREADY  out  1  read address channel.
REQ-013 S_AXI_RDATA/RRESP/RVALID  out  DW/2/1 and S_AXI_RREADY  in  1  read data channel.
REQ-014 reg_out  out  NUM_REGS*DW  flattened register contents; register i is at bits [i*DW +: DW].
REQ-015 wr_pulse  out  NUM_REGS  one-cycle strobe per register on each committed write.
REQ-016 sts_set  in  DW  per-bit hardware set inputs for the status register (REQ-031).

Function
REQ-017 Decode: ADDR_LSB = log2(DW/8); index = addr[ADDR_LSB +: clog2(NUM_REGS)]; address bits below ADDR_LSB are ignored.
REQ-018 An address >= NUM_REGS*(DW/8) is out of range: writes are dropped with BRESP=SLVERR (2'b10); reads return RDATA=0 with RRESP=SLVERR.
REQ-019 Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
REQ-020 In W_IDLE, AWREADY=WREADY=1; AW and W are accepted independently in either order or in the same cycle.
REQ-021 W_HAVE_A: AWREADY=0, WREADY=1. W_HAVE_D: AWREADY=1, WREADY=0. Each channel is held until the other completes its handshake.
REQ-022 When the second handshake completes at edge N: register updated, wr_pulse[idx] high for the cycle after N, and BVALID=1 with BRESP=OKAY from edge N; state goes to W_RESP.
REQ-023 Commit honours WSTRB per byte; WSTRB=0 still returns OKAY and pulses wr_pulse.
REQ-024 In W_RESP, AWREADY=WREADY=0; BVALID and BRESP are held stable until BREADY; after the BREADY handshake the FSM returns to W_IDLE.
REQ-025 Read FSM states: R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1).
REQ-026 AR handshake at edge N registers RDATA/RRESP and sets RVALID from edge N; both are held stable until RREADY; the FSM then returns to R_IDLE.
REQ-027 The read and write paths are fully concurrent.
REQ-028 If an AR handshake and a write commit to the same register occur on the same edge, the read returns the pre-write value.
REQ-029 Read latency is 1 cycle from AR handshake to RVALID; write latency is 1 cycle from the last AW/W handshake to BVALID; the block supports one outstanding transaction per direction.

Reset
REQ-030 While ARESETN=0 at a clock edge: all registers go to 0; BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, wr_pulse=0; AWREADY=WREADY=ARREADY=0; both FSMs go to idle. Readies assert one cycle after reset is released. A transaction in progress when reset is asserted is discarded with no commit.

Configuration
REQ-031 With macro SD_AXIL_REGFILE_W1C_EN defined, register NUM_REGS-1 is a W1C status register: a bit is set when the corresponding sts_set bit is 1; writing 1 (with the byte strobe active) clears the bit; if set and clear occur on the same edge, set wins. Writing 0 has no effect.
REQ-032 Without SD_AXIL_REGFILE_W1C_EN, register NUM_REGS-1 is ordinary read/write and sts_set is ignored.

Verification
REQ-033 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read them back -> identical data, every BRESP/RRESP=OKAY.
REQ-034 W presented 3 cycles before AW (addr 0x4, data 0xA5A5A5A5) -> single commit and one BVALID; reg 1 = 0xA5A5A5A5; wr_pulse[1] high for exactly 1 cycle.
REQ-035 WSTRB=4'b0010, data 0xFFFFFFFF to a register holding 0x12345678 -> register reads 0x1234FF78.
REQ-036 Read of 0x10 and write of 0x10 with NUM_REGS=4 -> RDATA=0, RRESP=SLVERR, BRESP=SLVERR; no register changes.
REQ-037 BREADY/RREADY held low for 5 cycles -> BVALID/RVALID and their payloads stay stable, AWREADY/WREADY/ARREADY stay 0.
REQ-038 With W1C enabled: pulse sts_set=0x5, then write 0x1 to reg 3 -> reads 0x5 then 0x4; same-edge set bit0 and W1C bit0 -> bit0 remains 1.

Source files
------------

// File: rtl/sd_axil_regfile.sv
// AXI4-Lite slave register file with NUM_REGS registers of C_S_AXI_DATA_WIDTH bits.
// Independent write (AW/W/B) and read (AR/R) paths, one outstanding transaction each.
// Optional build macro SD_AXIL_REGFILE_W1C_EN turns the top register into a
// write-1-to-clear status register fed by sts_set (set wins over clear).
module sd_axil_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                  wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        sts_set
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int ADDR_LSB = $clog2(DW/8);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int unsigned REG_BYTES = NUM_REGS * (DW/8);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic                     active;
  logic [AW-1:0]            aw_addr_q;
  logic [DW-1:0]            wdata_q;
  logic [DW/8-1:0]          wstrb_q;
  logic                     aw_hs, w_hs, ar_hs, commit;
  logic [AW-1:0]            c_addr;
  logic [DW-1:0]            c_data, c_mask;
  logic [DW/8-1:0]          c_strb;
  logic [IDX_W-1:0]         c_idx, ar_idx;
  logic                     c_ok, ar_ok;
  logic [NUM_REGS-1:0]      wr_hit;
  logic [NUM_REGS-1:0][DW-1:0] regs;
  logic [1:0]               bresp_q, rresp_q;
  logic [DW-1:0]            rdata_q;
  logic [NUM_REGS-1:0]      wr_pulse_q;
  logic                     unused_ok;

  // Readies are gated by 'active' so they stay low through reset and for the first edge after it.
  assign S_AXI_AWREADY = active && (w_state == W_IDLE || w_state == W_HAVE_D);
  assign S_AXI_WREADY  = active && (w_state == W_IDLE || w_state == W_HAVE_A);
  assign S_AXI_ARREADY = active && (r_state == R_IDLE);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_out       = regs;
  assign wr_pulse      = wr_pulse_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit uses whichever channel was latched earlier, or the live bus if both arrive together.
  assign c_addr = (w_state == W_HAVE_A) ? aw_addr_q : S_AXI_AWADDR;
  assign c_data = (w_state == W_HAVE_D) ? wdata_q   : S_AXI_WDATA;
  assign c_strb = (w_state == W_HAVE_D) ? wstrb_q   : S_AXI_WSTRB;
  assign c_idx  = c_addr[ADDR_LSB +: IDX_W];
  assign c_ok   = 32'(c_addr) < REG_BYTES;
  assign ar_idx = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
  assign ar_ok  = 32'(S_AXI_ARADDR) < REG_BYTES;

`ifdef SD_AXIL_REGFILE_W1C_EN
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};
`else
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, sts_set};
`endif

  // Byte-strobe expansion and per-register write hit.
  always_comb begin
    c_mask = '0;
    wr_hit = '0;
    for (int unsigned b = 0; b < DW/8; b++) c_mask[b*8 +: 8] = {8{c_strb[b]}};
    for (int unsigned i = 0; i < NUM_REGS; i++)
      wr_hit[i] = commit && c_ok && (c_idx == IDX_W'(i));
  end

  // Write FSM next state; commit fires on the edge completing the second of AW/W.
  always_comb begin
    w_state_nxt = w_state;
    commit      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin commit = 1'b1; w_state_nxt = W_RESP; end
        else if (aw_hs)    w_state_nxt = W_HAVE_A;
        else if (w_hs)     w_state_nxt = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)  begin commit = 1'b1; w_state_nxt = W_RESP; end
      W_HAVE_D: if (aw_hs) begin commit = 1'b1; w_state_nxt = W_RESP; end
      W_RESP:   if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default:  w_state_nxt = W_IDLE;
    endcase
  end

  // Read FSM next state.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // State registers, ready enable and channel holding latches.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      active    <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      active  <= 1'b1;
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register array, write response and write strobes.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      regs       <= '0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_hit;
      if (commit) bresp_q <= c_ok ? 2'b00 : 2'b10;
`ifdef SD_AXIL_REGFILE_W1C_EN
      for (int unsigned i = 0; i < NUM_REGS-1; i++)
        if (wr_hit[i]) regs[i] <= (regs[i] & ~c_mask) | (c_data & c_mask);
      // Clear first, then OR in hardware sets so a same-edge set wins.
      regs[NUM_REGS-1] <= (regs[NUM_REGS-1] & ~(wr_hit[NUM_REGS-1] ? (c_data & c_mask) : '0))
                          | sts_set;
`else
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (wr_hit[i]) regs[i] <= (regs[i] & ~c_mask) | (c_data & c_mask);
`endif
    end
  end

  // Read data capture; reads the pre-write array contents on a same-edge commit.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else if (ar_hs) begin
      rdata_q <= ar_ok ? regs[ar_idx] : '0;
      rresp_q <= ar_ok ? 2'b00 : 2'b10;
    end
  end

endmodule

// File: tb/tb_sd_axil_regfile.sv
// Directed self-checking bench for sd_axil_regfile (default parameters).
// Define SD_AXIL_REGFILE_W1C_EN on both files to exercise the W1C status register.
module tb_sd_axil_regfile;

  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [7:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [7:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] reg_out;
  logic [3:0]   wr_pulse;
  logic [31:0]  sts_set;

  int errors = 0;
  int checks = 0;

  sd_axil_regfile #(
    .C_S_AXI_DATA_WIDTH(32),
    .NUM_REGS(4),
    .C_S_AXI_ADDR_WIDTH(8)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .sts_set(sts_set)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Full write transaction; inputs change on the falling edge, readies sampled there.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, aw_hs, w_hs;
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      n++;
      if (aw_hs) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
    end
    resp = 2'b11;
    if (!(aw_done && w_done)) begin
      check("wr_timeout", 1'b0, 1'b1);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end else begin
      check("wr_bvalid_latency", S_AXI_BVALID, 1'b1);
      resp = S_AXI_BRESP;
      S_AXI_BREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
      check("wr_bvalid_drop", S_AXI_BVALID, 1'b0);
    end
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic done, hs;
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      @(negedge ACLK);
      n++;
      if (hs) begin S_AXI_ARVALID = 1'b0; done = 1'b1; end
    end
    data = 32'hDEAD_0000; resp = 2'b11;
    if (!done) begin
      check("rd_timeout", 1'b0, 1'b1);
      S_AXI_ARVALID = 1'b0;
    end else begin
      check("rd_rvalid_latency", S_AXI_RVALID, 1'b1);
      data = S_AXI_RDATA; resp = S_AXI_RRESP;
      S_AXI_RREADY = 1'b1;
      @(negedge ACLK);
      S_AXI_RREADY = 1'b0;
      check("rd_rvalid_drop", S_AXI_RVALID, 1'b0);
    end
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  logic [31:0] exp3;
  int          pulse_cnt, bv_cnt;

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'b010; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b001; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    sts_set = '0;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    check("rst_valids", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}, 6'b0);
    check("rst_rdata", S_AXI_RDATA, 32'h0);
    check("rst_regs", reg_out, 128'h0);
    check("rst_wr_pulse", wr_pulse, 4'h0);
    ARESETN = 1'b1;
    check("rdy_at_release", S_AXI_ARREADY, 1'b0);
    @(negedge ACLK);
    check("rdy_after_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Basic write then read-back of all registers
`ifdef SD_AXIL_REGFILE_W1C_EN
    exp3 = 32'h0;      // writing 0x4 to a clear status register clears nothing
`else
    exp3 = 32'h4;
`endif
    for (int i = 0; i < 4; i++) begin
      do_write(8'(i*4), 32'(i+1), 4'hF, resp);
      check("basic_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(8'(i*4), rd, resp);
      check("basic_rdata", rd, 32'(i+1));
      check("basic_rresp", resp, 2'b00);
    end
    do_read(8'h0C, rd, resp);
    check("basic_rdata3", rd, exp3);
    check("basic_rresp3", resp, 2'b00);
    do_read(8'h06, rd, resp);
    check("low_addr_bits_ignored", rd, 32'h2);

    // W presented three cycles before AW
    @(negedge ACLK);
    S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    check("have_d_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b10);
    check("have_d_no_commit", {S_AXI_BVALID, wr_pulse}, 5'b0);
    repeat (2) @(negedge ACLK);
    S_AXI_AWADDR = 8'h04; S_AXI_AWVALID = 1'b1;
    pulse_cnt = 0; bv_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;
      if (n == 0) check("w_first_bresp", S_AXI_BRESP, 2'b00);
      pulse_cnt += int'(wr_pulse[1]);
      bv_cnt += int'(S_AXI_BVALID);
    end
    S_AXI_BREADY = 1'b0;
    check("w_first_pulse_cycles", pulse_cnt, 1);
    check("w_first_bvalid_cycles", bv_cnt, 1);
    check("w_first_reg1", reg_out[63:32], 32'hA5A5A5A5);

    // Byte strobes
    do_write(8'h08, 32'h12345678, 4'hF, resp);
    do_write(8'h08, 32'hFFFFFFFF, 4'b0010, resp);
    check("strb_bresp", resp, 2'b00);
    do_read(8'h08, rd, resp);
    check("strb_rdata", rd, 32'h1234FF78);

    // Out of range
    do_read(8'h10, rd, resp);
    check("oor_rdata", rd, 32'h0);
    check("oor_rresp", resp, 2'b10);
    do_write(8'h10, 32'hDEADBEEF, 4'hF, resp);
    check("oor_bresp", resp, 2'b10);
    check("oor_regs", reg_out, {exp3, 32'h1234FF78, 32'hA5A5A5A5, 32'h1});

    // Simultaneous read and write of reg 0, both responses stalled for 5 cycles
    @(negedge ACLK);
    S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 8'h00;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("conc_pulse", wr_pulse, 4'b0001);
    for (int n = 0; n < 5; n++) begin
      check("stall_ctrl", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID, S_AXI_RRESP,
                           S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 9'b1_00_1_00_000);
      check("stall_rdata_prewrite", S_AXI_RDATA, 32'h1);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    check("stall_release", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY},
          5'b00111);
    do_read(8'h00, rd, resp);
    check("conc_rdata_after", rd, 32'h77);

`ifdef SD_AXIL_REGFILE_W1C_EN
    // W1C status register
    @(negedge ACLK); sts_set = 32'h5;
    @(negedge ACLK); sts_set = 32'h0;
    do_read(8'h0C, rd, resp);
    check("w1c_set", rd, 32'h5);
    do_write(8'h0C, 32'h1, 4'hF, resp);
    do_read(8'h0C, rd, resp);
    check("w1c_clear", rd, 32'h4);
    do_write(8'h0C, 32'h0, 4'hF, resp);
    do_read(8'h0C, rd, resp);
    check("w1c_write0", rd, 32'h4);
    @(negedge ACLK);
    S_AXI_AWADDR = 8'h0C; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; sts_set = 32'h1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; sts_set = 32'h0;
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    do_read(8'h0C, rd, resp);
    check("w1c_set_wins", rd, 32'h5);
`else
    // Top register is ordinary storage; sts_set has no effect
    @(negedge ACLK); sts_set = 32'hFFFFFFFF;
    @(negedge ACLK); sts_set = 32'h0;
    do_read(8'h0C, rd, resp);
    check("sts_ignored", rd, 32'h4);
    do_write(8'h0C, 32'hCAFE0003, 4'hF, resp);
    do_read(8'h0C, rd, resp);
    check("reg3_rw", rd, 32'hCAFE0003);
`endif

    // Reset while a write is half-accepted
    @(negedge ACLK);
    S_AXI_AWADDR = 8'h04; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    check("mid_have_a", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b01);
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    check("mid_rst_regs", reg_out, 128'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("mid_rst_idle", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID}, 4'b1110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
